// File: rtl/sim_uart_pkg.sv
// Shared types and line levels for the simulated UART transmitter.
// Optional parity support in sim_uart_tx is enabled by defining SIM_UART_TX_PARITY_EN.
package sim_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/sim_uart_fifo.sv
// Character buffer: push/pop FIFO, zero-cycle read of the head entry.
// A push into a full FIFO succeeds only when a pop happens in the same cycle; otherwise o_drop flags it.
module sim_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_drop  = i_push && o_full && !w_rd_en;
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
        end
    end

endmodule

// File: rtl/sim_uart_tx.sv
// Simulated UART transmitter: buffers MMIO characters and sends 8N1 frames on tx (8E1 with SIM_UART_TX_PARITY_EN).
// Push-to-start-bit latency is two cycles; characters pushed into a full FIFO without a same-cycle pop are dropped.
module sim_uart_tx
    import sim_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_overflow;
`ifdef SIM_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic              w_pop;
    logic              w_baud_wrap;

    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_baud_wrap = (r_baud == BAUD_LAST);

    sim_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (char_valid),
        .i_dat   (char_in),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // tx is registered: each transition loads the level of the bit being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= IDLE_LEVEL;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= START;
                        r_tx    <= START_LEVEL;
                    end
                end
                START: begin
                    if (w_baud_wrap) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == BIT_LAST) begin
`ifdef SIM_UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= STOP_LEVEL;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
`ifdef SIM_UART_TX_PARITY_EN
                PARITY: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_tx    <= STOP_LEVEL;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                        r_tx    <= IDLE_LEVEL;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                    r_tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

`ifdef SIM_UART_TX_PARITY_EN
    // Even parity is captured at pop time, before the shift register is consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign tx        = r_tx;
    assign busy      = (r_state != IDLE) || !w_empty;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_sim_uart_tx.sv
// Scoreboarded bench for sim_uart_tx: a transaction-level occupancy model predicts accepted characters and
// frame start cycles; a line receiver decodes tx and checks each frame against the predictions.
module tb_sim_uart_tx;
    localparam int C = 4;
    localparam int D = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       tx, busy, fifo_full, overflow;

    sim_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents plus cycles until the transmitter can take the next character.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         exp_start_q[$];
    int         m_rem = 0;
    logic       m_ovf = 1'b0;
    logic       m_rst_evt = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            exp_start_q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
            m_rst_evt = 1'b1;
        end else begin
            m_rst_evt = 1'b0;
            if (m_rem == 0 && mq.size() > 0) begin
                void'(mq.pop_front());
                m_rem = FRAME;
                exp_start_q.push_back(cyc);
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (char_valid) begin
                if (mq.size() < D) begin
                    mq.push_back(char_in);
                    exp_q.push_back(char_in);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: status checks every cycle plus a receiver that captures whole frames.
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    int         rx_start = 0;
    logic       samples [FRAME];
    int         frames_rx = 0;
    logic [7:0] last_byte = 8'h00;
    int         rx_starts[$];

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", busy, (m_rem > 0 || mq.size() > 0));
            chk("fifo_full", fifo_full, (mq.size() == D));
            chk("overflow", overflow, m_ovf);
            if (m_rem == 0) chk("tx_idle_high", tx, 1);
            if (m_rst_evt) begin
                rx_active = 1'b0;
                rx_cnt = 0;
            end else if (rx_active) begin
                samples[rx_cnt] = tx;
                rx_cnt++;
                if (rx_cnt == FRAME) begin
                    logic       shape_ok;
                    logic [7:0] b;
                    logic       lvl;
                    shape_ok = 1'b1;
                    b = 8'h00;
                    for (int k = 0; k < 10; k++) begin
                        lvl = samples[k*C];
                        for (int j = 1; j < C; j++)
                            if (samples[k*C+j] !== lvl) shape_ok = 1'b0;
                        if (k == 0 && lvl !== 1'b0) shape_ok = 1'b0;
                        if (k == 9 && lvl !== 1'b1) shape_ok = 1'b0;
                        if (k >= 1 && k <= 8) b[k-1] = lvl;
                    end
                    chk("frame_shape", shape_ok, 1);
                    chk("frame_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("frame_data", b, exp_q.pop_front());
                    if (exp_start_q.size() != 0) chk("frame_start_cycle", rx_start, exp_start_q.pop_front());
                    rx_active = 1'b0;
                    frames_rx++;
                    last_byte = b;
                    rx_starts.push_back(rx_start);
                end
            end else if (tx == 1'b0) begin
                rx_active = 1'b1;
                rx_start = cyc;
                samples[0] = 1'b0;
                rx_cnt = 1;
            end
        end
    end

    task automatic push(input logic [7:0] c);
        char_valid = 1'b1;
        char_in = c;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((m_rem != 0 || mq.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle_timeout", (t < budget), 1);
        @(negedge clk);
    endtask

    initial begin
        int n0, n_push, s0;
        logic b2b_ok;

        // Reset held for three edges while a push strobe is active.
        rst = 1'b0;
        char_valid = 1'b1;
        char_in = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        char_valid = 1'b0;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_fifo_full", fifo_full, 0);
        idle_cycles(20);
        chk("reset_no_frame", frames_rx, 0);

        // Single character with two-cycle latency.
        n0 = frames_rx;
        n_push = cyc;
        push(8'h41);
        wait_idle(200);
        chk("single_count", frames_rx - n0, 1);
        chk("single_byte", last_byte, 8'h41);
        chk("single_latency", rx_starts[rx_starts.size()-1], n_push + 2);

        // Back-to-back frames, one idle cycle apart.
        n0 = frames_rx;
        push(8'h00);
        push(8'hFF);
        wait_idle(300);
        chk("b2b_count", frames_rx - n0, 2);
        chk("b2b_last_byte", last_byte, 8'hFF);
        b2b_ok = (rx_starts.size() >= 2);
        if (b2b_ok)
            chk("b2b_gap", rx_starts[rx_starts.size()-1] - rx_starts[rx_starts.size()-2], FRAME + 1);

        // Full FIFO with a push landing on the pop cycle.
        n0 = frames_rx;
        push(8'h10);
        push(8'h11);
        push(8'h12);
        push(8'h13);
        push(8'h14);
        chk("fullpop_full", fifo_full, 1);
        s0 = 0;
        while (!(m_rem == 0 && mq.size() == D) && s0 < 200) begin
            @(negedge clk);
            s0++;
        end
        chk("fullpop_reach_timeout", (s0 < 200), 1);
        push(8'h7E);
        wait_idle(600);
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_count", frames_rx - n0, 6);
        chk("fullpop_last", last_byte, 8'h7E);

        // Overflow: six consecutive pushes, the sixth is dropped.
        n0 = frames_rx;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        chk("ovf_set", overflow, 1);
        wait_idle(600);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_count", frames_rx - n0, 5);
        chk("ovf_last", last_byte, 8'h34);

        // Reset during data bit 3.
        n0 = frames_rx;
        n_push = cyc;
        push(8'hA5);
        s0 = 0;
        while (cyc < n_push + 2 + 4 * C + 1 && s0 < 100) begin
            @(negedge clk);
            s0++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_overflow", overflow, 0);
        idle_cycles(20);
        chk("midrst_no_frame", frames_rx - n0, 0);
        push(8'h5A);
        wait_idle(200);
        chk("midrst_next_count", frames_rx - n0, 1);
        chk("midrst_next_byte", last_byte, 8'h5A);

        // Random traffic with occasional bursts.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int j = 0; j < 5; j++) push(8'($urandom));
            end else if ($urandom_range(0, 11) == 0) begin
                push(8'($urandom));
            end else begin
                @(negedge clk);
            end
        end
        wait_idle(2000);
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
